// File: rtl/arbitro_wrr.sv
// Weighted round-robin scheduler from the four yellow class FIFOs into the blue FIFOs.
// It pops at most one yellow FIFO per cycle and pushes that word one cycle later to the blue FIFO named by its dest field.
module arbitro_wrr #(
  parameter int DATA_W  = 12,
  parameter int N_PORTS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic [7:0]        pesos,
  input  logic [3:0]        FIFO_empty,
  input  logic [DATA_W-1:0] data_p0,
  input  logic [DATA_W-1:0] data_p1,
  input  logic [DATA_W-1:0] data_p2,
  input  logic [DATA_W-1:0] data_p3,
  input  logic [3:0]        Almost_full,
  output logic [3:0]        Pops,
  output logic [3:0]        Push,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t                   state;
  logic [1:0]               ptr;
  logic [2:0]               credit;
  logic [DATA_W-1:0]        head [N_PORTS];
  logic [N_PORTS-1:0]       elig;
  logic [1:0]               pick;
  logic [1:0]               scan_idx;
  logic                     found;
  logic                     pop_en;

  assign head[0] = data_p0;
  assign head[1] = data_p1;
  assign head[2] = data_p2;
  assign head[3] = data_p3;

  // A port is eligible only if its destination blue FIFO can still take a word.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      elig[i] = !FIFO_empty[i] && !Almost_full[head[i][9:8]];
    end
  end

  // Rotating priority scan starting at ptr.
  always_comb begin
    pick     = ptr;
    scan_idx = ptr;
    found    = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      scan_idx = ptr + 2'(k);
      if (!found && elig[scan_idx]) begin
        pick  = scan_idx;
        found = 1'b1;
      end
    end
  end

  assign pop_en = (state == SERVE) && Enable && elig[grant];
  assign Pops   = pop_en ? (4'b0001 << grant) : 4'b0000;
  assign busy   = (state == SERVE);

  // Arbitration stage: IDLE picks a port and loads its credits, SERVE spends them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= 2'd0;
      credit <= 3'd0;
      grant  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Enable && found) begin
            grant  <= pick;
            credit <= {1'b0, pesos[{pick, 1'b0} +: 2]} + 3'd1;
            state  <= SERVE;
          end
        end
        SERVE: begin
          if (Enable) begin
            if (pop_en) begin
              credit <= credit - 3'd1;
              if (credit == 3'd1) begin
                state <= IDLE;
                ptr   <= grant + 2'd1;
              end
            end else begin
              state <= IDLE;
              ptr   <= grant + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Push stage: drains regardless of Enable; reset drops an in-flight word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Push     <= 4'b0000;
      data_out <= '0;
    end else begin
      if (pop_en) begin
        Push     <= 4'b0001 << head[grant][9:8];
        data_out <= head[grant];
      end else begin
        Push     <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_wrr.sv
// Randomized bench for arbitro_wrr against a queue-based behavioural scheduler model.
module tb_arbitro_wrr;
  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              Enable;
  logic [7:0]        pesos;
  logic [3:0]        FIFO_empty;
  logic [3:0]        Almost_full;
  logic [DATA_W-1:0] dp [4];
  logic [3:0]        Pops;
  logic [3:0]        Push;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        grant;
  logic              busy;

  arbitro_wrr #(.DATA_W(DATA_W), .N_PORTS(4)) dut (
    .clk(clk), .reset(reset), .Enable(Enable), .pesos(pesos),
    .FIFO_empty(FIFO_empty),
    .data_p0(dp[0]), .data_p1(dp[1]), .data_p2(dp[2]), .data_p3(dp[3]),
    .Almost_full(Almost_full), .Pops(Pops), .Push(Push),
    .data_out(data_out), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Yellow FIFO contents, head at index 0.
  logic [DATA_W-1:0] yq [4][$];

  // Scheduler model: which port holds the grant, how many pops it has left,
  // where the next scan starts and what word is travelling to the blue side.
  bit                m_busy;
  int                m_port;
  int                m_cred;
  int                m_ptr;
  bit                m_pv;
  int                m_pdest;
  logic [DATA_W-1:0] m_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit elig(input int i);
    logic [DATA_W-1:0] w;
    w = dp[i];
    return !FIFO_empty[i] && !Almost_full[w[9:8]];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_port = 0; m_cred = 0; m_ptr = 0;
    m_pv = 0; m_pdest = 0; m_dout = '0;
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < 4; i++) begin
      FIFO_empty[i] = (yq[i].size() == 0);
      dp[i]         = (yq[i].size() != 0) ? yq[i][0] : '0;
    end
  endtask

  task automatic check_outputs();
    int exp_pops;
    exp_pops = (m_busy && Enable && elig(m_port)) ? (1 << m_port) : 0;
    check("pops", 32'(Pops), 32'(exp_pops));
    check("push", 32'(Push), m_pv ? 32'(1 << m_pdest) : 32'd0);
    check("data_out", 32'(data_out), 32'(m_dout));
    check("grant", 32'(grant), 32'(m_port));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit pop;
    bit fnd;
    int idx;
    pop = m_busy && Enable && elig(m_port);
    if (pop) begin
      m_dout  = yq[m_port].pop_front();
      m_pdest = int'(m_dout[9:8]);
      m_pv    = 1;
    end else begin
      m_pv = 0;
    end
    if (!m_busy) begin
      fnd = 0;
      if (Enable) begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (!fnd && elig(idx)) begin
            fnd    = 1;
            m_port = idx;
            m_cred = ((int'(pesos) >> (2 * idx)) & 3) + 1;
            m_busy = 1;
          end
        end
      end
    end else if (Enable) begin
      if (pop) begin
        m_cred--;
        if (m_cred == 0) begin
          m_busy = 0;
          m_ptr  = (m_port + 1) % 4;
        end
      end else begin
        m_busy = 0;
        m_ptr  = (m_port + 1) % 4;
      end
    end
  endtask

  // mode 0: FIFOs left as they are; 1: every port kept non-empty with dest = own index;
  // 2: random refill with random words, random Enable/Almost_full/pesos and reset pulses.
  task automatic cycle(input int mode);
    logic [DATA_W-1:0] w;
    @(negedge clk);
    if (mode == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (yq[i].size() < 3) begin
          w = DATA_W'($urandom);
          w[9:8] = 2'(i);
          yq[i].push_back(w);
        end
      end
    end else if (mode == 2) begin
      Enable = ($urandom_range(0, 99) < 85);
      for (int i = 0; i < 4; i++) begin
        Almost_full[i] = ($urandom_range(0, 99) < 15);
        if ($urandom_range(0, 3) == 0 && yq[i].size() < 6) yq[i].push_back(DATA_W'($urandom));
      end
      if ($urandom_range(0, 19) == 0) pesos = 8'($urandom);
    end
    drive_fifos();
    #1;
    check_outputs();
    if (mode == 2 && m_pv && $urandom_range(0, 9) == 0) begin
      reset = 1'b0;
      #1;
      check("rst_push", 32'(Push), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pops", 32'(Pops), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_dout", 32'(data_out), 32'd0);
      #1;
      reset = 1'b1;
      model_reset();
    end
    model_step();
  endtask

  initial begin
    reset       = 1'b0;
    Enable      = 1'b1;
    pesos       = 8'hFF;
    Almost_full = 4'b0000;
    FIFO_empty  = 4'b0000;
    for (int i = 0; i < 4; i++) dp[i] = DATA_W'($urandom);
    #12;
    check("reset_pops", 32'(Pops), 32'd0);
    check("reset_push", 32'(Push), 32'd0);
    check("reset_dout", 32'(data_out), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) yq[i].delete();
    drive_fifos();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 10; n++) cycle(0);

    pesos = 8'h01;
    for (int n = 0; n < 24; n++) cycle(1);

    pesos = 8'hC0;
    for (int i = 0; i < 4; i++) yq[i].delete();
    for (int n = 0; n < 4; n++) yq[2].push_back(12'h2A5);
    for (int n = 0; n < 12; n++) cycle(0);

    for (int n = 0; n < 800; n++) cycle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
